// File: rtl/ptpv2_defines.sv
// ptpv2_defines: shared RTC field widths, constants and capture-state encoding
package ptpv2_defines;
    localparam int SEC_W = 48;
    localparam int NS_W = 32;
    localparam int STD_W = SEC_W + NS_W;
    localparam logic [NS_W-1:0] NS_PER_SEC_M1 = 32'd999_999_999;
    typedef enum logic {CAP_EMPTY = 1'b0, CAP_FULL = 1'b1} cap_state_t;
    // Out-of-range widths (zero or a full second and beyond) fall back to the default.
    function automatic logic [NS_W-1:0] eff_width(input logic [NS_W-1:0] w, input logic [NS_W-1:0] def_w);
        return (w != '0 && w <= NS_PER_SEC_M1) ? w : def_w;
    endfunction
endpackage

// File: rtl/pps_in_filter.sv
// pps_in_filter: synchronizes external PPS and emits a one-cycle accept after FILT_CYC high samples
module pps_in_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC = 4
) (
    input  logic rtc_clk,
    input  logic rst_n,
    input  logic pps_i,
    output logic accept
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0] cnt_q;
    logic s;
    assign s = sync_q[SYNC_STAGES-1];
    // Saturation at FILT_CYC makes the match below fire once per high run.
    assign accept = s && cnt_q == 8'(FILT_CYC - 1);
    always_ff @(posedge rtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pps_i};
            cnt_q <= !s ? 8'd0 : (cnt_q == 8'(FILT_CYC)) ? cnt_q : cnt_q + 8'd1;
        end
    end
endmodule

// File: rtl/rtc_pps_io.sv
// rtc_pps_io: PPS output generation on second rollover and filtered PPS input timestamp capture
module rtc_pps_io
    import ptpv2_defines::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC = 4,
    parameter logic [31:0] DEF_WIDTH_NS = 32'd500_000_000
) (
    input  logic rtc_clk,
    input  logic rst_n,
    input  logic [STD_W-1:0] rtc_std,
    input  logic pps_en,
    input  logic [NS_W-1:0] pps_width_ns,
    input  logic pps_i,
    input  logic pts_ack,
    output logic pps_o,
    output logic [STD_W-1:0] pts_std,
    output logic pts_vld,
    output logic pts_ovf
);
    logic [SEC_W-1:0] sec, sec_q;
    logic [NS_W-1:0] ns, width;
    logic first_vld, roll, pps_next, accept, load, ovf_next;
    cap_state_t state, state_next;

    assign sec = rtc_std[STD_W-1:NS_W];
    assign ns = rtc_std[NS_W-1:0];
    assign width = eff_width(pps_width_ns, DEF_WIDTH_NS);
    // Any change of seconds counts, including backward jumps and clears.
    assign roll = first_vld && sec != sec_q;
    assign pps_next = !pps_en ? 1'b0 : roll ? 1'b1 : (pps_o && ns >= width) ? 1'b0 : pps_o;
    assign pts_vld = state == CAP_FULL;

    always_ff @(posedge rtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q <= '0;
            first_vld <= 1'b0;
            pps_o <= 1'b0;
        end else begin
            sec_q <= sec;
            first_vld <= 1'b1;
            pps_o <= pps_next;
        end
    end

    pps_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_filt (
        .rtc_clk(rtc_clk),
        .rst_n(rst_n),
        .pps_i(pps_i),
        .accept(accept)
    );

    always_comb begin
        state_next = state;
        load = 1'b0;
        ovf_next = pts_ovf;
        if (state == CAP_EMPTY) begin
            load = accept;
            state_next = accept ? CAP_FULL : CAP_EMPTY;
        end else if (accept) begin
            // A simultaneous ack frees the slot for the new capture.
            load = pts_ack;
            ovf_next = pts_ack ? pts_ovf : 1'b1;
        end else if (pts_ack) begin
            state_next = CAP_EMPTY;
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge rtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CAP_EMPTY;
            pts_std <= '0;
            pts_ovf <= 1'b0;
        end else begin
            state <= state_next;
            pts_std <= load ? rtc_std : pts_std;
            pts_ovf <= ovf_next;
        end
    end
endmodule
